clk_div_bank: RTL

Parametrised bank of CH independent programmable clock dividers running off the 50 MHz system clock, the successor to the fixed divide-by-16 generator. Each channel produces a registered near-50%-duty divided clock and a one-cycle tick enable. Each channel's divide ratio is reprogrammable at run time through a valid/ready port, with updates applied glitch-free at the period boundary. It sits beside the cipher core and supplies slow strobes to test, UART and LED logic.

---
 rtl/clkdiv_pkg.sv | 11 +
 rtl/clk_div_bank_if.sv | 13 +
 rtl/clkdiv_chan.sv | 49 ++++
 rtl/clk_div_bank.sv | 42 ++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and divisor helpers for the clock divider bank
package clkdiv_pkg;
  localparam int DIV_MIN = 2;
  localparam int DIV_DEFAULT_PKG = 16;
  function automatic logic [31:0] div_clamp(input logic [31:0] d);
    return (d < DIV_MIN) ? 32'(DIV_MIN) : d;
  endfunction
  function automatic logic [31:0] div_half(input logic [31:0] d);
    return d - (d >> 1);
  endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: divisor write port (valid/ready, target channel, divisor)
interface clk_div_bank_if #(
  parameter int CH = 4,
  parameter int CNT_W = 16,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
);
  logic cfg_valid;
  logic cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  modport master(output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave(input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with shadowed divisor applied at the period boundary
module clkdiv_chan import clkdiv_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int DIV_DEFAULT = 16
) (
  input  logic clk50,
  input  logic reset,
  input  logic en_i,
  input  logic sync_i,
  input  logic we_i,
  input  logic [CNT_W-1:0] div_i,
  output logic pending_o,
  output logic clk_out_o,
  output logic tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d, wdiv;
  logic pend_q, pend_d, clk_q, tick_q, wrap, idle;
  assign wdiv = CNT_W'(div_clamp(32'(div_i)));
  assign wrap = cnt_q == div_q - 1'b1;
  assign idle = !en_i || sync_i;
  // Idle/sync parks the counter at 0 and applies a new divisor at once; running applies it only at wrap
  always_comb begin
    cnt_d = (idle || wrap) ? '0 : cnt_q + 1'b1;
    div_d = idle ? (we_i ? wdiv : pend_q ? shadow_q : div_q) : (wrap && pend_q) ? shadow_q : div_q;
    shadow_d = we_i ? wdiv : shadow_q;
    pend_d = !idle && (we_i || (pend_q && !wrap));
  end
  // State and outputs registered from the next counter value so outputs align with cnt
  always_ff @(posedge clk50) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DIV_DEFAULT);
      shadow_q <= CNT_W'(DIV_DEFAULT);
      pend_q <= 1'b0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      clk_q <= 32'(cnt_d) >= div_half(32'(div_d));
      tick_q <= cnt_d == div_d - 1'b1;
    end
  end
  assign pending_o = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: CH programmable clock dividers; CLKDIV_SYNC_EN adds a sync input that phase-aligns all channels
module clk_div_bank import clkdiv_pkg::*; #(
  parameter int CH = 4,
  parameter int CNT_W = 16,
  parameter int DIV_DEFAULT = DIV_DEFAULT_PKG
) (
  input  logic clk50,
  input  logic reset,
  input  logic [CH-1:0] ch_en,
`ifdef CLKDIV_SYNC_EN
  input  logic sync,
`endif
  clk_div_bank_if.slave cfg,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int NP = 1 << CHW;
  logic [CH-1:0] pending;
  logic [NP-1:0] pend_all;
  logic sync_w;
`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif
  assign pend_all = NP'(pending);
  assign cfg.cfg_ready = ~pend_all[cfg.cfg_ch];
  for (genvar i = 0; i < CH; i++) begin : g_chan
    clkdiv_chan #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) u_chan (
      .clk50(clk50),
      .reset(reset),
      .en_i(ch_en[i]),
      .sync_i(sync_w),
      .we_i(cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_ch == CHW'(i)),
      .div_i(cfg.cfg_div),
      .pending_o(pending[i]),
      .clk_out_o(clk_out[i]),
      .tick_o(tick[i])
    );
  end
endmodule
